// File: rtl/vram_scanout_pkg.sv
// vram_scanout_pkg: shared definitions for the frame-buffer scan-out slice.
//   - default source resolution (H_SRC_DEF x V_SRC_DEF)
//   - RGB565 field positions used by the colour expander
//   - page-flip state encoding
package vram_scanout_pkg;

    localparam int unsigned H_SRC_DEF = 400;
    localparam int unsigned V_SRC_DEF = 240;

    // RGB565 field positions
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic {
        FLIP_IDLE    = 1'b0,
        FLIP_PENDING = 1'b1
    } flip_state_t;

endpackage

// File: rtl/vram_scanout_rgb565_expand.sv
// rgb565_expand: combinational RGB565 -> RGB888 expander.
// Each channel is widened by replicating its field LSB into the new low bits,
// matching the colour path used elsewhere in the system.
//   rgb565  in  16  packed R5G6B5 word
//   rgb888  out 24  packed R8G8B8 word
module rgb565_expand
    import vram_scanout_pkg::*;
(
    input  logic [15:0] rgb565,
    output logic [23:0] rgb888
);

    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;

    assign red   = rgb565[R_MSB:R_LSB];
    assign green = rgb565[G_MSB:G_LSB];
    assign blue  = rgb565[B_MSB:B_LSB];

    assign rgb888 = {red,   {3{red[0]}},
                     green, {2{green[0]}},
                     blue,  {3{blue[0]}}};

endmodule

// File: rtl/vram_scanout_sig_delay.sv
// sig_delay: generic DEPTH-stage shift register with synchronous reset.
//   clk   in  1      clock
//   rst   in  1      synchronous reset, active-high (all stages <= RESET_VAL)
//   din   in  WIDTH  value entering the pipe
//   dout  out WIDTH  din delayed by DEPTH cycles
module sig_delay #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= RESET_VAL;
            end
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: frame-buffer scan-out between the LCD timing generator and
// the 16-bit buffer RAM. Maps LCD pixel coordinates to 2x-upscaled VRAM word
// addresses relative to the active page base, expands RGB565 to RGB888 and
// delays DE/HSYNC/VSYNC by RD_LAT+2 cycles so they line up with colour.
// A requested page base takes effect only at a frame boundary (VSYNC going
// active) and is acknowledged with a one-cycle pulse.
//   iACLK, iRST                 clock, synchronous active-high reset
//   iHADDR, iVADDR              LCD pixel column / row
//   iDE, iHSYNC, iVSYNC         LCD timing in
//   iFLIP_REQ, iFLIP_BASE       page-flip request pulse and new base
//   oFLIP_ACK, oFLIP_BUSY       flip applied pulse / flip pending
//   oVRAM_ADDR, oVRAM_RDEN      registered VRAM read address / enable
//   iVRAM_DATA                  RGB565 read data, RD_LAT cycles after address
//   oCOLOR, oDE, oHSYNC, oVSYNC aligned RGB888 and timing out
module vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int unsigned H_SRC       = H_SRC_DEF,
    parameter int unsigned V_SRC       = V_SRC_DEF,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned RD_LAT      = 1,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic              iACLK,
    input  logic              iRST,
    input  logic [9:0]        iHADDR,
    input  logic [8:0]        iVADDR,
    input  logic              iDE,
    input  logic              iHSYNC,
    input  logic              iVSYNC,
    input  logic              iFLIP_REQ,
    input  logic [ADDR_W-1:0] iFLIP_BASE,
    output logic              oFLIP_ACK,
    output logic              oFLIP_BUSY,
    output logic [ADDR_W-1:0] oVRAM_ADDR,
    output logic              oVRAM_RDEN,
    input  logic [15:0]       iVRAM_DATA,
    output logic [23:0]       oCOLOR,
    output logic              oDE,
    output logic              oHSYNC,
    output logic              oVSYNC
);

    localparam int unsigned LAT    = RD_LAT + 2;
    localparam logic [31:0] H_BITS = 32'(H_SRC);

    // ------------------------------------------------------------------
    // Page flip
    // ------------------------------------------------------------------
    flip_state_t       flip_state;
    logic [ADDR_W-1:0] active_base;
    logic [ADDR_W-1:0] pending_base;
    logic              vsync_q;
    logic              frame_boundary;

    assign frame_boundary = (iVSYNC == SYNC_ACTIVE) && (vsync_q != SYNC_ACTIVE);

    // A request arriving on the boundary cycle is never applied at that same
    // boundary: only the base that was already pending gets applied, and the
    // new one is held for the next boundary.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            flip_state   <= FLIP_IDLE;
            active_base  <= '0;
            pending_base <= '0;
            vsync_q      <= ~SYNC_ACTIVE;
            oFLIP_ACK    <= 1'b0;
        end else begin
            vsync_q   <= iVSYNC;
            oFLIP_ACK <= 1'b0;
            case (flip_state)
                FLIP_IDLE: begin
                    if (iFLIP_REQ) begin
                        pending_base <= iFLIP_BASE;
                        flip_state   <= FLIP_PENDING;
                    end
                end
                FLIP_PENDING: begin
                    if (frame_boundary) begin
                        active_base <= pending_base;
                        oFLIP_ACK   <= 1'b1;
                        flip_state  <= iFLIP_REQ ? FLIP_PENDING : FLIP_IDLE;
                    end
                    if (iFLIP_REQ) begin
                        pending_base <= iFLIP_BASE;
                    end
                end
                default: flip_state <= FLIP_IDLE;
            endcase
        end
    end

    assign oFLIP_BUSY = (flip_state == FLIP_PENDING);

    // ------------------------------------------------------------------
    // Address stage
    // ------------------------------------------------------------------
    logic [9:0]        src_col;
    logic [8:0]        src_row;
    logic              in_range;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] pix_addr;

    assign src_col  = iHADDR >> 1;
    assign src_row  = iVADDR >> 1;
    assign in_range = (32'(src_col) < H_SRC) && (32'(src_row) < V_SRC);

    // row * H_SRC as a sum of shifted copies for each set bit of the constant
    always_comb begin
        row_off = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (H_BITS[i]) begin
                row_off = row_off + (ADDR_W'(src_row) << i);
            end
        end
    end

    assign pix_addr = active_base + row_off + ADDR_W'(src_col);

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            oVRAM_ADDR <= '0;
            oVRAM_RDEN <= 1'b0;
        end else begin
            oVRAM_ADDR <= pix_addr;
            oVRAM_RDEN <= in_range & iDE;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline alignment
    // ------------------------------------------------------------------
    // Read enable doubles as the "show" flag; delayed to meet the read data.
    logic show_q;

    sig_delay #(
        .WIDTH     (1),
        .DEPTH     (RD_LAT),
        .RESET_VAL (1'b0)
    ) u_show_delay (
        .clk  (iACLK),
        .rst  (iRST),
        .din  (oVRAM_RDEN),
        .dout (show_q)
    );

    logic [2:0] timing_q;

    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (LAT),
        .RESET_VAL ({1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE})
    ) u_timing_delay (
        .clk  (iACLK),
        .rst  (iRST),
        .din  ({iDE, iHSYNC, iVSYNC}),
        .dout (timing_q)
    );

    assign {oDE, oHSYNC, oVSYNC} = timing_q;

    // ------------------------------------------------------------------
    // Colour output register
    // ------------------------------------------------------------------
    logic [23:0] rgb888;

    rgb565_expand u_expand (
        .rgb565 (iVRAM_DATA),
        .rgb888 (rgb888)
    );

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            oCOLOR <= '0;
        end else begin
            oCOLOR <= show_q ? rgb888 : '0;
        end
    end

endmodule
